// File: rtl/matrix_panel_scanner.sv
// matrix_panel_scanner
//   Read-out stage for a HUB75 RGB LED matrix. It fetches 6-bit pixel-pair
//   words from the frame RAM read port and shifts one row pair into the panel.
//   The row is then latched and displayed for ON_CYCLES clocks. All outputs are
//   registered, and each carries the value of the state the scanner is in.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   en           1 = scan the panel, 0 = idle (panel blanked)
//   raddr        frame RAM read address {row, col}
//   read_data    RAM word for the previous cycle's raddr; [5:3]=rgb0, [2:0]=rgb1
//   panel_rgb0   top-half pixel (row r)
//   panel_rgb1   bottom-half pixel (row r+ROWS/2)
//   panel_a      row-pair address
//   panel_clk    shift clock; the panel samples on its rising edge
//   panel_lat    latch strobe, active high
//   panel_oe     output enable, active low (1 = blanked)
//   frame_start  one-cycle pulse in the first FETCH of a frame
module matrix_panel_scanner #(
  parameter int COLS      = 32,
  parameter int ROWS      = 32,
  parameter int ON_CYCLES = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  output logic [$clog2(ROWS/2*COLS)-1:0]     raddr,
  input  logic [5:0]                         read_data,
  output logic [2:0]                         panel_rgb0,
  output logic [2:0]                         panel_rgb1,
  output logic [$clog2(ROWS/2)-1:0]          panel_a,
  output logic                               panel_clk,
  output logic                               panel_lat,
  output logic                               panel_oe,
  output logic                               frame_start
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS/2);
  localparam int AW = $clog2(ROWS/2*COLS);
  localparam int OW = $clog2(ON_CYCLES+1);

  localparam logic [CW-1:0] COL_LAST = CW'(COLS-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS/2-1);
  localparam logic [OW-1:0] ON_LAST  = OW'(ON_CYCLES-1);

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, SETUP, CLOCK, LATCH, DISPLAY
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [OW-1:0]   r_on_cnt;
  logic [AW-1:0]   r_raddr;
  logic [2:0]      r_rgb0;
  logic [2:0]      r_rgb1;
  logic [RW-1:0]   r_a;
  logic            r_pclk;
  logic            r_lat;
  logic            r_oe;
  logic            r_frame_start;

  logic [RW-1:0]   w_row_next;

  assign w_row_next = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_on_cnt      <= '0;
      r_raddr       <= '0;
      r_rgb0        <= '0;
      r_rgb1        <= '0;
      r_a           <= '0;
      r_pclk        <= 1'b0;
      r_lat         <= 1'b0;
      r_oe          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        IDLE: begin
          r_oe   <= 1'b1;
          r_pclk <= 1'b0;
          r_lat  <= 1'b0;
          r_row  <= '0;
          r_col  <= '0;
          if (en) begin
            r_state       <= FETCH;
            r_raddr       <= '0;
            r_frame_start <= 1'b1;
          end
        end
        FETCH: r_state <= CAPTURE;
        CAPTURE: begin
          // RAM data for the address issued in FETCH is valid this cycle.
          r_rgb0  <= read_data[5:3];
          r_rgb1  <= read_data[2:0];
          r_state <= SETUP;
        end
        SETUP: begin
          r_pclk  <= 1'b1;
          r_state <= CLOCK;
        end
        CLOCK: begin
          r_pclk <= 1'b0;
          if (r_col == COL_LAST) begin
            r_lat   <= 1'b1;
            r_a     <= r_row;
            r_state <= LATCH;
          end else begin
            r_col   <= r_col + 1'b1;
            r_raddr <= {r_row, r_col + 1'b1};
            r_state <= FETCH;
          end
        end
        LATCH: begin
          r_lat    <= 1'b0;
          r_oe     <= 1'b0;
          r_on_cnt <= '0;
          r_state  <= DISPLAY;
        end
        DISPLAY: begin
          if (r_on_cnt == ON_LAST) begin
            r_oe  <= 1'b1;
            r_col <= '0;
            // en is sampled only here; disabling drops the row back to 0
            // because re-enable always restarts the frame.
            if (en) begin
              r_row         <= w_row_next;
              r_raddr       <= {w_row_next, CW'(0)};
              r_frame_start <= (w_row_next == '0);
              r_state       <= FETCH;
            end else begin
              r_row   <= '0;
              r_state <= IDLE;
            end
          end else begin
            r_on_cnt <= r_on_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign raddr       = r_raddr;
  assign panel_rgb0  = r_rgb0;
  assign panel_rgb1  = r_rgb1;
  assign panel_a     = r_a;
  assign panel_clk   = r_pclk;
  assign panel_lat   = r_lat;
  assign panel_oe    = r_oe;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_matrix_panel_scanner.sv
module tb_matrix_panel_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [8:0] raddr;
  logic [5:0] read_data = '0;
  logic [2:0] panel_rgb0, panel_rgb1;
  logic [3:0] panel_a;
  logic       panel_clk, panel_lat, panel_oe, frame_start;

  always #5 clk = ~clk;

  matrix_panel_scanner #(.COLS(32), .ROWS(32), .ON_CYCLES(256)) dut (
    .clk(clk), .rst(rst), .en(en), .raddr(raddr), .read_data(read_data),
    .panel_rgb0(panel_rgb0), .panel_rgb1(panel_rgb1), .panel_a(panel_a),
    .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe(panel_oe),
    .frame_start(frame_start)
  );

  // Frame RAM model, one-cycle read latency.
  logic [5:0] mem [0:511];
  always @(posedge clk) read_data <= mem[raddr];

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    int         n;
    logic       oe;
    logic       lat;
    logic       pclk;
    logic [3:0] a;
    logic       fs;
    logic [2:0] rgb0;
    logic [2:0] rgb1;
    logic [8:0] raddr;
  } vec_t;

  vec_t vt [17];

  initial begin
    logic [22:0] act_p, exp_p;
    int lat_n, lat_bad, last_lat, exp_row, a_bad;
    int run, run_n, run_bad, run_a_bad, run_a, clk_bad;
    int fs_n, fs_bad, last_fs, cov_bad, last_low;
    int cov [512];
    logic p_clk, p_oe;

    for (int i = 0; i < 512; i++) mem[i] = 6'(i);
    mem[0]  = 6'b101_010;
    mem[31] = 6'b111_001;

    //          rst   en    n     oe    lat   clk   a     fs    rgb0    rgb1    raddr
    vt[0]  = '{1'b1, 1'b0, 3,    1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000, 3'b000, 9'd0};
    vt[1]  = '{1'b0, 1'b0, 1000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000, 3'b000, 9'd0};
    vt[2]  = '{1'b0, 1'b1, 1,    1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 3'b000, 3'b000, 9'd0};
    vt[3]  = '{1'b0, 1'b1, 1,    1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000, 3'b000, 9'd0};
    vt[4]  = '{1'b0, 1'b1, 1,    1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b101, 3'b010, 9'd0};
    vt[5]  = '{1'b0, 1'b1, 1,    1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 3'b101, 3'b010, 9'd0};
    vt[6]  = '{1'b0, 1'b1, 1,    1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b101, 3'b010, 9'd1};
    vt[7]  = '{1'b0, 1'b1, 2,    1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000, 3'b001, 9'd1};
    vt[8]  = '{1'b0, 1'b1, 121,  1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 3'b111, 3'b001, 9'd31};
    vt[9]  = '{1'b0, 1'b1, 1,    1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 3'b111, 3'b001, 9'd31};
    vt[10] = '{1'b0, 1'b1, 1,    1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'b111, 3'b001, 9'd31};
    vt[11] = '{1'b0, 1'b1, 255,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'b111, 3'b001, 9'd31};
    vt[12] = '{1'b0, 1'b1, 1,    1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b111, 3'b001, 9'd32};
    vt[13] = '{1'b0, 1'b1, 1,    1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b111, 3'b001, 9'd32};
    vt[14] = '{1'b0, 1'b1, 1,    1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b100, 3'b000, 9'd32};
    vt[15] = '{1'b0, 1'b1, 126,  1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 3'b111, 3'b111, 9'd63};
    vt[16] = '{1'b0, 1'b1, 1,    1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 3'b111, 3'b111, 9'd63};

    #1;
    for (int v = 0; v < 17; v++) begin
      rst = vt[v].rst;
      en  = vt[v].en;
      repeat (vt[v].n) tick();
      act_p = {panel_oe, panel_lat, panel_clk, panel_a, frame_start, panel_rgb0, panel_rgb1, raddr};
      exp_p = {vt[v].oe, vt[v].lat, vt[v].pclk, vt[v].a, vt[v].fs, vt[v].rgb0, vt[v].rgb1, vt[v].raddr};
      n_vec++;
      if (act_p !== exp_p) begin
        n_err++;
        $display("FAIL vec%0d {oe,lat,clk,a,fs,rgb0,rgb1,raddr}: got %b expected %b", v, act_p, exp_p);
      end
    end

    // Free run of two frames: row timing, row order, frame pulses, address coverage.
    rst = 1'b1; en = 1'b0;
    repeat (3) tick();
    rst = 1'b0; en = 1'b1;
    lat_n = 0; lat_bad = 0; last_lat = -1; exp_row = 0; a_bad = 0;
    run = 0; run_n = 0; run_bad = 0; run_a_bad = 0; run_a = 0; clk_bad = 0;
    fs_n = 0; fs_bad = 0; last_fs = -1; cov_bad = 0;
    for (int i = 0; i < 512; i++) cov[i] = 0;
    p_clk = panel_clk; p_oe = panel_oe;
    for (int c = 1; c <= 13120; c++) begin
      tick();
      if (panel_lat) begin
        if (last_lat >= 0 && c - last_lat != 385) lat_bad++;
        if (panel_a != 4'(exp_row)) a_bad++;
        run_a = exp_row;
        exp_row = (exp_row + 1) % 16;
        last_lat = c;
        lat_n++;
      end
      if (frame_start) begin
        if (last_fs >= 0 && c - last_fs != 6160) fs_bad++;
        last_fs = c;
        fs_n++;
      end
      if (panel_clk && !p_clk && fs_n == 1) cov[raddr]++;
      if (panel_clk != p_clk && (!panel_oe || !p_oe)) clk_bad++;
      if (!panel_oe) begin
        run++;
        if (panel_a != 4'(run_a)) run_a_bad++;
      end else if (!p_oe) begin
        if (run != 256) run_bad++;
        run_n++;
        run = 0;
      end
      p_clk = panel_clk; p_oe = panel_oe;
    end
    for (int i = 0; i < 512; i++) if (cov[i] != 1) cov_bad++;
    chk("lat_count", lat_n, 34);
    chk("lat_spacing_bad", lat_bad, 0);
    chk("a_sequence_bad", a_bad, 0);
    chk("oe_runs", run_n, 34);
    chk("oe_run_len_bad", run_bad, 0);
    chk("oe_run_a_bad", run_a_bad, 0);
    chk("clk_edges_oe_low", clk_bad, 0);
    chk("frame_start_count", fs_n, 3);
    chk("frame_start_spacing_bad", fs_bad, 0);
    chk("raddr_coverage_bad", cov_bad, 0);

    // Disable mid-row: row 5 col 10 CLOCK, row finishes, then idle.
    rst = 1'b1; en = 1'b0;
    repeat (2) tick();
    rst = 1'b0; en = 1'b1;
    repeat (1969) tick();
    chk("r5c10_pclk", panel_clk, 1);
    chk("r5c10_raddr", raddr, 170);
    en = 1'b0;
    lat_n = 0; run = 0; run_a_bad = 0; fs_n = 0; last_low = 0; clk_bad = 0;
    p_clk = panel_clk;
    for (int c = 1970; c <= 2400; c++) begin
      tick();
      if (panel_lat) lat_n++;
      if (frame_start) fs_n++;
      if (!panel_oe) begin
        run++;
        last_low = c;
        if (panel_a != 4'd5) run_a_bad++;
        if (panel_clk != p_clk) clk_bad++;
      end
      p_clk = panel_clk;
    end
    chk("dis_lat_count", lat_n, 1);
    chk("dis_oe_low_cycles", run, 256);
    chk("dis_last_oe_low", last_low, 2310);
    chk("dis_a_bad", run_a_bad, 0);
    chk("dis_clk_edges_oe_low", clk_bad, 0);
    chk("dis_frame_start", fs_n, 0);
    chk("idle_oe", panel_oe, 1);
    en = 1'b1;
    tick();
    chk("reen_frame_start", frame_start, 1);
    chk("reen_raddr", raddr, 0);
    repeat (128) tick();
    chk("reen_lat", panel_lat, 1);
    chk("reen_a", panel_a, 0);

    // Reset in the middle of row 7 display.
    rst = 1'b1; en = 1'b0;
    repeat (2) tick();
    rst = 1'b0; en = 1'b1;
    repeat (2924) tick();
    chk("r7_oe", panel_oe, 0);
    chk("r7_a", panel_a, 7);
    rst = 1'b1;
    tick();
    chk("rst_oe", panel_oe, 1);
    chk("rst_a", panel_a, 0);
    chk("rst_lat", panel_lat, 0);
    chk("rst_clk", panel_clk, 0);
    rst = 1'b0;
    tick();
    chk("rel_frame_start", frame_start, 1);
    chk("rel_raddr", raddr, 0);
    repeat (2) tick();
    chk("rel_rgb0", panel_rgb0, 5);
    chk("rel_rgb1", panel_rgb1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
